// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared constants and divisor clamp for the programmable divider family.
package freq_div_pkg;

    localparam int          DIV_W_DEFAULT = 8;
    localparam int unsigned DIV_MIN       = 2;

    // Divisors below DIV_MIN would give a zero-length half period.
    function automatic int unsigned clampDiv(input int unsigned value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage

// File: rtl/freq_div_cnt.sv
// freq_div_cnt: period counter with wrap detect and preset, shared by the divider channels.
module freq_div_cnt #(
    parameter int DIV_W   = 8,
    parameter int RST_VAL = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    input  logic             preset_i,
    input  logic [DIV_W-1:0] preset_val_i,
    input  logic [DIV_W-1:0] last_i,
    output logic [DIV_W-1:0] cnt_next_o,
    output logic             wrap_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign wrap_o = (cnt_q == last_i);

    always_comb begin
        cnt_d = cnt_q;
        if (preset_i) begin
            cnt_d = preset_val_i;
        end else if (adv_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + DIV_W'(1);
        end
    end

    assign cnt_next_o = cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= DIV_W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/freq_div_prog.sv
// freq_div_prog: runtime-programmable integer clock divider producing clk_out and a tick enable.
// Defining FREQ_DIV_PROG_SYNC_CLR_EN adds sync_clr_i for phase-aligning several dividers.
module freq_div_prog
    import freq_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
`ifdef FREQ_DIV_PROG_SYNC_CLR_EN
    input  logic             sync_clr_i,
`endif
    input  logic [DIV_W-1:0] div_val_i,
    input  logic             div_load_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic [DIV_W-1:0] div_cur_o
);

    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [DIV_W-1:0] load_val;
    logic [DIV_W-1:0] next_n;
    logic [DIV_W-1:0] cnt_next;
    logic             wrap;
    logic             sync_clr;

`ifdef FREQ_DIV_PROG_SYNC_CLR_EN
    assign sync_clr = sync_clr_i;
`else
    assign sync_clr = 1'b0;
`endif

    assign load_val = DIV_W'(clampDiv(32'(div_val_i)));
    assign next_n   = pend_vld_q ? div_pend_q : div_cur_q;

    // A clear presets the counter to its last state so the next enabled edge wraps.
    freq_div_cnt #(
        .DIV_W   (DIV_W),
        .RST_VAL (DIV_DEFAULT - 1)
    ) u_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .adv_i        (en_i),
        .preset_i     (sync_clr),
        .preset_val_i (next_n - DIV_W'(1)),
        .last_i       (div_cur_q - DIV_W'(1)),
        .cnt_next_o   (cnt_next),
        .wrap_o       (wrap)
    );

    always_comb begin
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_vld_d = pend_vld_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        if (sync_clr) begin
            div_cur_d  = next_n;
            pend_vld_d = 1'b0;
            clk_out_d  = 1'b0;
        end else begin
            if (div_load_i) begin
                div_pend_d = load_val;
                pend_vld_d = 1'b1;
            end
            if (en_i) begin
                // A load coinciding with the wrap sizes the period that starts now.
                if (wrap) begin
                    div_cur_d  = div_load_i ? load_val : next_n;
                    pend_vld_d = 1'b0;
                    tick_d     = 1'b1;
                end
                clk_out_d = (cnt_next < (div_cur_d >> 1));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_cur_q  <= DEF_N;
            div_pend_q <= DEF_N;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign div_cur_o = div_cur_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// tb_freq_div_prog: randomized scoreboard bench comparing freq_div_prog to a period-level waveform model.
`timescale 1ns/1ps
module tb_freq_div_prog;

    localparam int DIV_W       = 8;
    localparam int DIV_DEFAULT = 4;

    typedef struct packed {
        logic             clkOut;
        logic             tick;
        logic [DIV_W-1:0] divCur;
    } expect_t;

    logic             clk = 1'b0;
    logic             rstN;
    logic             en;
    logic             divLoad;
    logic [DIV_W-1:0] divVal;
`ifdef FREQ_DIV_PROG_SYNC_CLR_EN
    logic             syncClr;
`endif
    logic             clkOut;
    logic             tick;
    logic [DIV_W-1:0] divCur;

    expect_t    expQ[$];
    logic [1:0] waveQ[$];
    int         curN;
    int         pendN;
    bit         pendV;
    bit         lastClk;
    int         assertCount = 0;
    int         failCount   = 0;
    int         cycle       = 0;

    always #5 clk = ~clk;

    freq_div_prog #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .en_i       (en),
`ifdef FREQ_DIV_PROG_SYNC_CLR_EN
        .sync_clr_i (syncClr),
`endif
        .div_val_i  (divVal),
        .div_load_i (divLoad),
        .clk_out_o  (clkOut),
        .tick_o     (tick),
        .div_cur_o  (divCur)
    );

    // Model: each new period is expanded into its full waveform and consumed one enabled cycle at a time.
    task automatic modelStep(input bit r, input bit e, input bit l, input int v, input bit sc);
        expect_t    x;
        logic [1:0] w;
        int         lv;
        lv = (v < 2) ? 2 : v;
        if (!r) begin
            waveQ.delete();
            curN    = DIV_DEFAULT;
            pendV   = 0;
            lastClk = 0;
            x = {1'b0, 1'b0, DIV_W'(curN)};
        end else if (sc) begin
            if (pendV) curN = pendN;
            pendV = 0;
            waveQ.delete();
            lastClk = 0;
            x = {1'b0, 1'b0, DIV_W'(curN)};
        end else begin
            if (e && waveQ.size() == 0) begin
                if (l) curN = lv;
                else if (pendV) curN = pendN;
                pendV = 0;
                for (int i = 0; i < curN; i++) waveQ.push_back({i < curN / 2, i == 0});
            end else if (l) begin
                pendN = lv;
                pendV = 1;
            end
            if (e) begin
                w = waveQ.pop_front();
                lastClk = w[1];
                x = {w[1], w[0], DIV_W'(curN)};
            end else begin
                x = {lastClk, 1'b0, DIV_W'(curN)};
            end
        end
        expQ.push_back(x);
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit l, input int v, input bit sc);
        @(negedge clk);
        rstN    = r;
        en      = e;
        divLoad = l;
        divVal  = DIV_W'(v);
`ifdef FREQ_DIV_PROG_SYNC_CLR_EN
        syncClr = sc;
`endif
        modelStep(r, e, l, v, sc);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        assertCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, actual, required);
        end
    endtask

    always @(posedge clk) begin
        expect_t x;
        #1;
        cycle++;
        if (expQ.size() > 0) begin
            x = expQ.pop_front();
            checkOutput("clk_out", 32'(clkOut), 32'(x.clkOut));
            checkOutput("tick",    32'(tick),   32'(x.tick));
            checkOutput("div_cur", 32'(divCur), 32'(x.divCur));
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit sc;
        rstN = 1'b0; en = 1'b0; divLoad = 1'b0; divVal = '0;
`ifdef FREQ_DIV_PROG_SYNC_CLR_EN
        syncClr = 1'b0;
`endif
        repeat (2) applyStimulus(0, 0, 0, 0, 0);
        // Default N=4 waveform, then load 5 early in a period.
        repeat (12) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 5, 0);
        repeat (16) applyStimulus(1, 1, 0, 0, 0);
        // Load 0 clamps to 2.
        applyStimulus(1, 1, 1, 0, 0);
        repeat (10) applyStimulus(1, 1, 0, 0, 0);
        // N=6 with a three-cycle freeze mid-period.
        applyStimulus(1, 1, 1, 6, 0);
        repeat (9) applyStimulus(1, 1, 0, 0, 0);
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        repeat (12) applyStimulus(1, 1, 0, 0, 0);
        // N=7, load 9, then reset mid-period discards the pending load.
        applyStimulus(1, 1, 1, 7, 0);
        repeat (10) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 9, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (10) applyStimulus(1, 1, 0, 0, 0);
        // Repeated loads before a wrap: last value wins.
        applyStimulus(1, 1, 1, 3, 0);
        applyStimulus(1, 1, 1, 1, 0);
        applyStimulus(1, 0, 1, 8, 0);
        repeat (20) applyStimulus(1, 1, 0, 0, 0);
`ifdef FREQ_DIV_PROG_SYNC_CLR_EN
        applyStimulus(1, 1, 1, 6, 0);
        repeat (3) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 3, 1);
        repeat (14) applyStimulus(1, 1, 0, 0, 0);
`endif
        for (int n = 0; n < 3000; n++) begin
            sc = 0;
`ifdef FREQ_DIV_PROG_SYNC_CLR_EN
            sc = ($urandom_range(0, 39) == 0);
`endif
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 4) != 0,
                          $urandom_range(0, 9) == 0,
                          ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                                        : int'($urandom_range(0, 12)),
                          sc);
        end
        @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/freq_div_prog.md
Name: freq_div_prog

Overview:
- Runtime-programmable integer clock divider, fully synchronous to `clk`; no derived clock drives any flop.
- Produces a divided square wave `clk_out` and a one-cycle `tick` strobe at the start of each output period.
- Replaces fixed ripple-chained divide-by-2^k stages; downstream logic should use `tick` as a clock enable.

Parameters:
- DIV_W, 8, width of the divisor and the internal counter.
- DIV_DEFAULT, 4, divisor in force after reset; must satisfy 2 <= DIV_DEFAULT <= 2^DIV_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  count enable; low freezes the divider.
- div_val  in  DIV_W  requested divisor N.
- div_load  in  1  single-cycle strobe capturing div_val.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle pulse coinciding with each clk_out rising edge, registered.
- div_cur  out  DIV_W  divisor currently in force.

Behaviour:
- Reset: sampled only on a rising `clk` edge with rst==0.
  - Effects: div_cur=DIV_DEFAULT, div_pend=DIV_DEFAULT, pend_vld=0, cnt=DIV_DEFAULT-1, clk_out=0, tick=0.
  - A reset asserted mid-period aborts that period immediately; there is no partial-period completion.
- Counting: with en=1, cnt advances 0..N-1, where N=div_cur. It wraps to 0 on the cycle after cnt==N-1 (wrap event).
- clk_out: registered from next-cnt. clk_out=1 when next-cnt < floor(N/2), otherwise 0.
  - Even N gives 50% duty.
  - Odd N is high floor(N/2) cycles and low ceil(N/2) cycles.
- tick: registered; equals 1 for exactly the cycle in which cnt==0 after a wrap.
  - First tick: the first enabled edge after reset produces cnt=0, clk_out=1, tick=1. Period 1 starts with no dead cycle.
- Freeze: en=0 holds cnt and clk_out, and forces tick=0. Resuming continues the same phase.
- Divisor load:
  - div_load=1 captures div_val into div_pend and sets pend_vld.
  - The pending value is applied only on a wrap event: div_cur<=div_pend, pend_vld<=0. Output periods are never truncated.
  - div_load on the same cycle as a wrap: the newly presented div_val takes effect for the period that starts at that wrap.
  - Repeated div_load before a wrap: the last value wins.
  - div_val of 0 or 1 is clamped to 2 at capture.
- div_cur updates on the same edge the new period's tick asserts.
- Latency: div_load to new period length is at most N_old cycles.
- No combinational path from any input to any output.

Optional Feature:
- Macro: FREQ_DIV_PROG_SYNC_CLR_EN.
- Defined:
  - Adds input `sync_clr` (1 bit).
  - sync_clr=1 on an edge forces cnt=N-1, clk_out=0, tick=0. If pend_vld is set, the pending divisor is applied at the same time.
  - The next enabled edge starts a fresh period: tick=1.
  - sync_clr has priority over en and div_load. rst has priority over sync_clr.
  - Used to phase-align multiple dividers.
- Undefined: the port is absent, and phase is set only by reset.

Decomposition:
- Shared package `freq_div_pkg`: DIV_W default, DIV_MIN=2 constant, clamp function (value < DIV_MIN -> DIV_MIN).
- No sub-module required. An optional leaf `freq_div_cnt` (counter plus wrap detect) is acceptable if reused by later channelised dividers.

Test Plan:
- Reset, then en=1 with default N=4 -> clk_out 1,1,0,0 repeating. tick at cycles 1,5,9…; div_cur=4.
- div_val=5 loaded at cnt==1 -> current period completes at 4 cycles, then clk_out high 2 / low 3 cycles. tick spacing becomes 5. div_cur changes exactly at that tick.
- div_load of 0 -> div_cur=2 after the next wrap. clk_out toggles every cycle; tick every 2 cycles.
- N=6, en dropped for 3 cycles at cnt==2 -> cnt and clk_out held, no tick, period stretches to 9 cycles, phase is otherwise preserved.
- rst=0 asserted mid-period at N=7 after loading 9 -> next edge outputs: clk_out=0, tick=0, div_cur=4. A pending load is discarded.
- FREQ_DIV_PROG_SYNC_CLR_EN: two instances with N=3 and N=6 pulsed with sync_clr together -> both tick on the same cycle, and on every 6th cycle thereafter.
